neck_diff_calc: RTL and testbench
=================================

// Module: neck_diff_calc
// PURPOSE
//   Front-end conditioning stage for the neck (necking) detector. Takes raw 12-bit ADC
//   samples of the arc-voltage/resistance channel and block-averages them. Produces the
//   averaged value plus saturated 1st/2nd/3rd-order differences as 13-bit signed words.
//   Emits a one-cycle en_judge strobe per new result; these outputs drive the downstream
//   neck-judge stage directly.
// PARAMETERS
//   AVG_LOG2   2   log2 of samples per averaging block; legal range 0..4 (0 = no averaging)
// PORTS
//   clk                 in   1   system clock (single clock domain)
//   rst_n               in   1   synchronous, active-low reset
//   adc_valid           in   1   qualifies adc_raw for one cycle; may be back-to-back or gapped
//   adc_raw             in   12  unsigned ADC sample, 0..4095
//   adc_data            out  13  signed; averaged sample, zero-extended (0..4095)
//   first_order_data    out  13  signed; saturated avg[n]-avg[n-1]
//   second_order_data   out  13  signed; saturated d1[n]-d1[n-1]
//   third_order_data    out  13  signed; saturated d2[n]-d2[n-1]
//   en_judge            out  1   one-cycle strobe: the four data outputs were updated this cycle
// BEHAVIOUR
//   - Reset (rst_n==0 at clk edge): all outputs 0, sum/count/history/warm-up cleared,
//     adc_valid ignored that cycle. Reset overrides everything, including mid-block.
//   - Accumulate: each accepted sample adds to a (12+AVG_LOG2)-bit sum; count wraps at 2^AVG_LOG2.
//     On the final sample of a block, register avg = sum>>AVG_LOG2 (truncating) and pulse
//     avg_stb next cycle. Sum restarts with the next sample; no sample is lost at block boundaries.
//     An all-4095 block yields avg exactly 4095 (downstream matches on 4095).
//   - Difference stage, on avg_stb: d1 = avg - avg_prev (14-bit); d2 = d1s - d1s_prev;
//     d3 = d2s - d2s_prev. Compute each in 14 bits, then saturate to [-4096, +4095]
//     (suffix s = saturated). Histories store saturated values.
//   - Register all four outputs together; en_judge=1 in the same cycle they change.
//   - Latency: final sample of a block accepted at edge k -> outputs/en_judge valid after edge k+2.
//   - Warm-up: 2-bit counter of completed blocks, saturating at 3. Blocks 1-3 only load history;
//     outputs stay 0 and en_judge stays 0. Every block from the 4th onward updates outputs and
//     pulses en_judge.
//   - Between strobes, outputs hold their last values; en_judge=0.
//   - Back-to-back adc_valid with AVG_LOG2=0: one en_judge per sample, full throughput.
//   - adc_valid coincident with avg_stb/output cycle: accepted normally, pipeline is non-stalling.
// STRUCTURE
//   - Package neck_pkg: localparam NECK_DW=13, NECK_MAX=13'sd4095, NECK_MIN=-13'sd4096, and
//     function neck_sat(input signed [13:0]) -> signed [12:0]. Shared with the judge stage.
//   - Sub-module neck_block_avg (accumulator, count, avg, avg_stb); parent holds the difference
//     pipeline, histories and warm-up counter.
// TESTING
//   1 Reset: hold rst_n=0 with adc_valid=1 for 5 cycles -> all outputs 0, en_judge never 1.
//   2 AVG_LOG2=0, samples 0,10,20,30,40 back-to-back -> no strobe for first 3 samples. 4th:
//     en_judge 2 cycles after, outputs (30,10,0,0). 5th -> (40,10,0,0).
//   3 AVG_LOG2=0, samples 0,1,4,9,16 -> at 9: (9,5,2,0); at 16: (16,7,2,0).
//   4 Saturation, AVG_LOG2=0: samples 0,4095,0,4095 -> (4095,4095,4095,4095),
//     because d2 raw 8190->4095 and d3 raw 8191->4095.
//   5 AVG_LOG2=2, gapped adc_valid: 3 blocks of 4x4095, then samples 1,2,3,6 -> strobe only
//     after 4th block, outputs (3,-4092,-4092,-4092).
//   6 Reset mid-block (AVG_LOG2=2): run to steady state, feed 2 samples, rst_n=0 one cycle ->
//     outputs 0. Partial sum discarded; next en_judge only after 4 further full blocks (16 samples).

Source files
------------

// File: rtl/neck_pkg.sv
// Shared types and saturation helper for the neck detector front end and judge stage.
package neck_pkg;
  localparam int NECK_DW = 13;
  localparam logic signed [NECK_DW-1:0] NECK_MAX = 13'sd4095;
  localparam logic signed [NECK_DW-1:0] NECK_MIN = -13'sd4096;

  typedef logic signed [NECK_DW-1:0] neck_word_t;

  typedef struct packed {
    neck_word_t avg;
    neck_word_t d1;
    neck_word_t d2;
    neck_word_t d3;
  } neck_res_t;

  function automatic neck_word_t neck_sat(input logic signed [NECK_DW:0] x);
    if (x > 14'sd4095) return NECK_MAX;
    else if (x < -14'sd4096) return NECK_MIN;
    else return x[NECK_DW-1:0];
  endfunction
endpackage

// File: rtl/neck_diff_calc_if.sv
// ADC sample input and conditioned-result output bundle of the neck front end.
interface neck_diff_calc_if;
  import neck_pkg::*;
  logic       adc_valid;
  logic [11:0] adc_raw;
  neck_word_t adc_data;
  neck_word_t first_order_data;
  neck_word_t second_order_data;
  neck_word_t third_order_data;
  logic       en_judge;

  modport master (
    output adc_valid, adc_raw,
    input  adc_data, first_order_data, second_order_data, third_order_data, en_judge
  );
  modport slave (
    input  adc_valid, adc_raw,
    output adc_data, first_order_data, second_order_data, third_order_data, en_judge
  );
endinterface

// File: rtl/neck_block_avg.sv
// Block averager: sums 2^AVG_LOG2 accepted samples and emits the truncated mean with a strobe.
module neck_block_avg #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_valid,
  input  logic [11:0] adc_raw,
  output logic [11:0] avg,
  output logic        avg_stb
);
  localparam int SW = 12 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [SW-1:0] sum, sum_nxt;
  logic [CW-1:0] cnt;
  logic          last;

  // The final sample is folded in combinationally so the sum register can restart at once.
  assign sum_nxt = sum + SW'(adc_raw);
  assign last    = (AVG_LOG2 == 0) || (cnt == CW'((1 << AVG_LOG2) - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum     <= '0;
      cnt     <= '0;
      avg     <= '0;
      avg_stb <= 1'b0;
    end else begin
      avg_stb <= 1'b0;
      if (adc_valid) begin
        if (last) begin
          sum     <= '0;
          cnt     <= '0;
          avg     <= sum_nxt[SW-1:AVG_LOG2];
          avg_stb <= 1'b1;
        end else begin
          sum <= sum_nxt;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/neck_diff_calc.sv
// Neck detector front end: block average plus saturated 1st/2nd/3rd-order differences.
module neck_diff_calc
  import neck_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input logic             clk,
  input logic             rst_n,
  neck_diff_calc_if.slave bus
);
  logic [11:0] avg, avg_prev;
  logic        avg_stb;
  neck_word_t  d1s, d2s, d3s, d1_prev, d2_prev;
  neck_res_t   res_q;
  logic        res_vld;
  logic [1:0]  warm;

  neck_block_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_valid (bus.adc_valid),
    .adc_raw   (bus.adc_raw),
    .avg       (avg),
    .avg_stb   (avg_stb)
  );

  // Chained differences; each stage consumes the saturated result of the previous one.
  always_comb begin
    d1s = neck_sat($signed({2'b00, avg}) - $signed({2'b00, avg_prev}));
    d2s = neck_sat($signed({d1s[12], d1s}) - $signed({d1_prev[12], d1_prev}));
    d3s = neck_sat($signed({d2s[12], d2s}) - $signed({d2_prev[12], d2_prev}));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avg_prev              <= '0;
      d1_prev               <= '0;
      d2_prev               <= '0;
      warm                  <= '0;
      res_q                 <= '0;
      res_vld               <= 1'b0;
      bus.adc_data          <= '0;
      bus.first_order_data  <= '0;
      bus.second_order_data <= '0;
      bus.third_order_data  <= '0;
      bus.en_judge          <= 1'b0;
    end else begin
      res_vld      <= 1'b0;
      bus.en_judge <= 1'b0;
      if (avg_stb) begin
        avg_prev <= avg;
        d1_prev  <= d1s;
        d2_prev  <= d2s;
        res_q    <= '{avg: {1'b0, avg}, d1: d1s, d2: d2s, d3: d3s};
        // The first three blocks only prime the histories.
        if (warm != 2'd3) warm <= warm + 2'd1;
        else              res_vld <= 1'b1;
      end
      if (res_vld) begin
        bus.adc_data          <= res_q.avg;
        bus.first_order_data  <= res_q.d1;
        bus.second_order_data <= res_q.d2;
        bus.third_order_data  <= res_q.d3;
        bus.en_judge          <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_neck_diff_calc.sv
// Bench for neck_diff_calc: one DUT with AVG_LOG2=0 and one with AVG_LOG2=2, checked by a block-level model.
module tb_neck_diff_calc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld [2];
  logic [11:0] raw [2];
  logic signed [12:0] o_a [2], o_1 [2], o_2 [2], o_3 [2];
  logic        o_en [2];

  neck_diff_calc_if b0 ();
  neck_diff_calc_if b1 ();

  assign b0.adc_valid = vld[0];
  assign b0.adc_raw   = raw[0];
  assign b1.adc_valid = vld[1];
  assign b1.adc_raw   = raw[1];
  assign o_a[0] = b0.adc_data;           assign o_a[1] = b1.adc_data;
  assign o_1[0] = b0.first_order_data;   assign o_1[1] = b1.first_order_data;
  assign o_2[0] = b0.second_order_data;  assign o_2[1] = b1.second_order_data;
  assign o_3[0] = b0.third_order_data;   assign o_3[1] = b1.third_order_data;
  assign o_en[0] = b0.en_judge;          assign o_en[1] = b1.en_judge;

  neck_diff_calc #(.AVG_LOG2(0)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  neck_diff_calc #(.AVG_LOG2(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int idx; int due; int a; int d1; int d2; int d3; } ev_t;
  ev_t pend[$];
  ev_t obs[$];

  int lg [2] = '{0, 2};
  int acc [2], cnt [2], ha [2], hd1 [2], hd2 [2], warm [2];
  int ea [2], e1 [2], e2 [2], e3 [2], een [2];
  int cyc = 0;

  logic s_rst = 1'b0;
  logic s_v [2];
  logic [11:0] s_r [2];
  always @(posedge clk) begin
    s_rst <= rst_n;
    s_v   <= vld;
    s_r   <= raw;
  end

  function automatic int sat(input int x);
    if (x > 4095) return 4095;
    if (x < -4096) return -4096;
    return x;
  endfunction

  task automatic chk(input string name, input int i, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, i, cyc, act, exp);
    end
  endtask

  // Model + per-cycle compare, evaluated mid-cycle on what the last edge sampled.
  initial begin
    for (int i = 0; i < 2; i++) begin
      acc[i] = 0; cnt[i] = 0; ha[i] = 0; hd1[i] = 0; hd2[i] = 0; warm[i] = 0;
      ea[i] = 0; e1[i] = 0; e2[i] = 0; e3[i] = 0; een[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (!s_rst) begin
        pend.delete();
        for (int i = 0; i < 2; i++) begin
          acc[i] = 0; cnt[i] = 0; ha[i] = 0; hd1[i] = 0; hd2[i] = 0; warm[i] = 0;
          ea[i] = 0; e1[i] = 0; e2[i] = 0; e3[i] = 0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (s_v[i] === 1'b1) begin
            acc[i] += int'(s_r[i]);
            cnt[i]++;
            if (cnt[i] == (1 << lg[i])) begin
              ev_t e;
              e.idx = i; e.due = cyc + 2;
              e.a  = acc[i] / (1 << lg[i]);
              e.d1 = sat(e.a - ha[i]);
              e.d2 = sat(e.d1 - hd1[i]);
              e.d3 = sat(e.d2 - hd2[i]);
              ha[i] = e.a; hd1[i] = e.d1; hd2[i] = e.d2;
              if (warm[i] == 3) pend.push_back(e);
              else warm[i]++;
              acc[i] = 0; cnt[i] = 0;
            end
          end
        end
      end
      een[0] = 0; een[1] = 0;
      while (pend.size() > 0 && pend[0].due == cyc) begin
        ev_t e;
        e = pend.pop_front();
        een[e.idx] = 1; ea[e.idx] = e.a; e1[e.idx] = e.d1; e2[e.idx] = e.d2; e3[e.idx] = e.d3;
      end
      for (int i = 0; i < 2; i++) begin
        chk("en_judge", i, int'(o_en[i]), een[i]);
        chk("adc_data", i, int'(o_a[i]), ea[i]);
        chk("first_order", i, int'(o_1[i]), e1[i]);
        chk("second_order", i, int'(o_2[i]), e2[i]);
        chk("third_order", i, int'(o_3[i]), e3[i]);
        if (o_en[i] === 1'b1) begin
          ev_t e;
          e.idx = i; e.due = cyc;
          e.a = int'(o_a[i]); e.d1 = int'(o_1[i]); e.d2 = int'(o_2[i]); e.d3 = int'(o_3[i]);
          obs.push_back(e);
        end
      end
    end
  end

  task automatic put(input int idx, input int v);
    @(posedge clk); #1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    vld[idx] = 1'b1;
    raw[idx] = 12'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vld[0] = 1'b0; vld[1] = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0; vld[0] = 1'b0; vld[1] = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
    obs.delete();
  endtask

  // Literal expectation for the next strobe seen on a given DUT.
  task automatic pop_expect(input string name, input int idx, input int a, input int d1,
                            input int d2, input int d3);
    int k;
    k = -1;
    for (int j = 0; j < obs.size(); j++) if (k < 0 && obs[j].idx == idx) k = j;
    n_cmp++;
    if (k < 0) begin
      n_bad++;
      $display("FAIL %s: no en_judge strobe seen, expected (%0d,%0d,%0d,%0d)", name, a, d1, d2, d3);
    end else begin
      if (obs[k].a != a || obs[k].d1 != d1 || obs[k].d2 != d2 || obs[k].d3 != d3) begin
        n_bad++;
        $display("FAIL %s: got (%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)", name,
                 obs[k].a, obs[k].d1, obs[k].d2, obs[k].d3, a, d1, d2, d3);
      end
      obs.delete(k);
    end
  endtask

  task automatic expect_none(input string name);
    n_cmp++;
    if (obs.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d unexpected strobes expected 0", name, obs.size());
    end
    obs.delete();
  endtask

  initial begin
    int t0 [5] = '{0, 10, 20, 30, 40};
    int t3 [5] = '{0, 1, 4, 9, 16};
    int t4 [4] = '{0, 4095, 0, 4095};
    int t5 [4] = '{1, 2, 3, 6};
    int t6 [4] = '{50, 51, 52, 56};

    // Reset held with valid asserted.
    vld[0] = 1'b1; vld[1] = 1'b1; raw[0] = 12'd4095; raw[1] = 12'd4095;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1; vld[0] = 1'b0; vld[1] = 1'b0;
    idle(3);
    expect_none("reset_no_strobe");

    do_reset(2);
    foreach (t0[j]) put(0, t0[j]);
    idle(4);
    pop_expect("ramp_s4", 0, 30, 10, 0, 0);
    pop_expect("ramp_s5", 0, 40, 10, 0, 0);
    expect_none("ramp_extra");

    do_reset(2);
    foreach (t3[j]) put(0, t3[j]);
    idle(4);
    pop_expect("square_s4", 0, 9, 5, 2, 0);
    pop_expect("square_s5", 0, 16, 7, 2, 0);
    expect_none("square_extra");

    do_reset(2);
    foreach (t4[j]) put(0, t4[j]);
    idle(4);
    pop_expect("saturate", 0, 4095, 4095, 4095, 4095);
    expect_none("saturate_extra");

    do_reset(2);
    for (int j = 0; j < 12; j++) begin
      put(1, 4095);
      idle(j % 3);
    end
    idle(4);
    expect_none("avg_warmup");
    foreach (t5[j]) begin
      put(1, t5[j]);
      idle(j % 2);
    end
    idle(4);
    pop_expect("avg_block4", 1, 3, -4092, -4092, -4092);
    expect_none("avg_extra");

    do_reset(2);
    for (int b = 1; b <= 4; b++) for (int j = 0; j < 4; j++) put(1, 100 * b);
    idle(4);
    pop_expect("steady", 1, 400, 100, 0, 0);
    put(1, 5);
    put(1, 5);
    do_reset(1);
    for (int b = 0; b < 3; b++) for (int j = 0; j < 4; j++) put(1, 40 + 4 * b);
    for (int j = 0; j < 3; j++) put(1, t6[j]);
    idle(4);
    expect_none("midblock_reset_15");
    put(1, t6[3]);
    idle(4);
    pop_expect("midblock_reset_16", 1, 52, 4, 0, 0);
    expect_none("midblock_extra");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
